// File: rtl/ppu_pkg.sv
// ppu_pkg -- shared constants and types for the PPU palette shadow.
//   PAL_BASE_ADDR    : VRAM address of palette entry 0
//   DEF_NUM_PAL      : default number of palettes
//   DEF_PAL_ENTRIES  : default entries per palette
//   DEF_DATA_W       : default bits per palette entry
//   pal_state_t      : load sequencer states (IDLE/ISSUE/DRAIN/DONE)
package ppu_pkg;

  localparam logic [15:0] PAL_BASE_ADDR   = 16'h3F00;
  localparam int          DEF_NUM_PAL     = 8;
  localparam int          DEF_PAL_ENTRIES = 4;
  localparam int          DEF_DATA_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pal_state_t;

endpackage

// File: rtl/ppu_rd_lat_pipe.sv
// ppu_rd_lat_pipe -- fixed-latency shift register carrying {valid, data}.
// Delays an issued read tag by DEPTH cycles so it lines up with the
// returning VRAM data.
//   clk        : clock
//   rst        : asynchronous active-low clear of every stage
//   in_valid   : tag valid entering stage 0
//   in_data    : tag entering stage 0
//   out_valid  : tag valid leaving the last stage
//   out_data   : tag leaving the last stage
//   empty_next : pipe will hold no valid tag after the coming edge
module ppu_rd_lat_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             empty_next
);

  logic [DEPTH-1:0] stage_valid;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_prev;
    logic [WIDTH-1:0] data_prev;

    if (gi == 0) begin : g_head
      assign valid_prev = in_valid;
      assign data_prev  = in_data;
    end else begin : g_body
      assign valid_prev = g_stage[gi-1].valid_reg;
      assign data_prev  = g_stage[gi-1].data_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= valid_prev;
        data_reg  <= data_prev;
      end
    end

    assign stage_valid[gi] = valid_reg;
  end

  assign out_valid = g_stage[DEPTH-1].valid_reg;
  assign out_data  = g_stage[DEPTH-1].data_reg;

  // The last stage drains on the coming edge, so only the earlier stages
  // and the input decide whether anything is still in flight afterwards.
  assign empty_next = !in_valid &&
                      ((stage_valid & ~(DEPTH'(1) << (DEPTH - 1))) == '0);

endmodule

// File: rtl/ppu_palette_cache.sv
// ppu_palette_cache -- palette shadow for the PPU pixel mux.
// Bulk-loads every palette entry from VRAM through a pipelined read port and
// keeps the shadow coherent by snooping CPU writes to the palette window.
//   clk           : clock
//   rst           : asynchronous active-low reset
//   start         : request a full reload (honoured only when idle)
//   busy          : load in progress, through the done cycle
//   done          : one-cycle pulse at load completion
//   vram_addr_out : VRAM read address (0 when not issuing)
//   vram_rd       : VRAM read strobe, one per issued address
//   vram_data_in  : VRAM read data, RD_LAT cycles after its strobe
//   snoop_we      : CPU palette write strobe
//   snoop_addr    : CPU write address
//   snoop_data    : CPU write data
//   colors_out    : all entries, entry i at [i*DATA_W +: DATA_W]
//   bg_colors     : background half of colors_out
//   spr_colors    : sprite half of colors_out
module ppu_palette_cache
  import ppu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                NUM_PAL     = DEF_NUM_PAL,
  parameter int                PAL_ENTRIES = DEF_PAL_ENTRIES,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(PAL_BASE_ADDR),
  parameter int                RD_LAT      = 1,
  parameter bit                MIRROR_EN   = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic [ADDR_W-1:0]                        vram_addr_out,
  output logic                                     vram_rd,
  input  logic [DATA_W-1:0]                        vram_data_in,
  input  logic                                     snoop_we,
  input  logic [ADDR_W-1:0]                        snoop_addr,
  input  logic [DATA_W-1:0]                        snoop_data,
  output logic [NUM_PAL*PAL_ENTRIES*DATA_W-1:0]    colors_out,
  output logic [NUM_PAL*PAL_ENTRIES*DATA_W/2-1:0]  bg_colors,
  output logic [NUM_PAL*PAL_ENTRIES*DATA_W/2-1:0]  spr_colors
);

  localparam int N      = NUM_PAL * PAL_ENTRIES;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int HALF_W = N * DATA_W / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // ---------------- load sequencer ----------------
  pal_state_t       state_reg, state_next;
  logic [IDX_W-1:0] issue_idx_reg, issue_idx_next;
  logic             issue_valid;
  logic             pipe_out_valid;
  logic [IDX_W-1:0] pipe_out_idx;
  logic             pipe_empty_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      issue_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      issue_idx_reg <= issue_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    issue_idx_next = issue_idx_reg;
    issue_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = ISSUE;
          issue_idx_next = '0;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (issue_idx_reg == LAST_IDX) begin
          state_next     = DRAIN;
          issue_idx_next = '0;
        end else begin
          issue_idx_next = issue_idx_reg + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (pipe_empty_next) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  // Entry 0 of every palette is fetched from the universal background slot
  // when mirroring is enabled.
  logic              issue_mirror;
  logic [ADDR_W-1:0] issue_addr;

  assign issue_mirror  = MIRROR_EN && ((int'(issue_idx_reg) % PAL_ENTRIES) == 0);
  assign issue_addr    = issue_mirror ? BASE_ADDR : BASE_ADDR + ADDR_W'(issue_idx_reg);
  assign vram_rd       = issue_valid;
  assign vram_addr_out = issue_valid ? issue_addr : '0;

  ppu_rd_lat_pipe #(
    .WIDTH (IDX_W),
    .DEPTH (RD_LAT)
  ) u_rd_lat_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (issue_valid),
    .in_data    (issue_idx_reg),
    .out_valid  (pipe_out_valid),
    .out_data   (pipe_out_idx),
    .empty_next (pipe_empty_next)
  );

  // ---------------- snoop decode ----------------
  // The window repeats every N entries across the whole high-byte page.
  logic             snoop_hit;
  logic [IDX_W-1:0] snoop_idx;
  logic             snoop_mirror;

  assign snoop_hit    = snoop_we && (snoop_addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign snoop_idx    = IDX_W'(snoop_addr % ADDR_W'(N));
  assign snoop_mirror = MIRROR_EN && ((int'(snoop_idx) % PAL_ENTRIES) == 0);

  // ---------------- colour storage ----------------
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_entry
    localparam bit IS_ALIAS = ((gi % PAL_ENTRIES) == 0);
    logic [DATA_W-1:0] color_reg;
    logic              snoop_sel;
    logic              cap_sel;

    assign snoop_sel = snoop_hit &&
                       ((snoop_idx == IDX_W'(gi)) || (snoop_mirror && IS_ALIAS));
    assign cap_sel   = pipe_out_valid && (pipe_out_idx == IDX_W'(gi));

    // A CPU write wins over a VRAM capture landing in the same cycle; the
    // CPU value is the newer one.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        color_reg <= '0;
      end else if (snoop_sel) begin
        color_reg <= snoop_data;
      end else if (cap_sel) begin
        color_reg <= vram_data_in;
      end
    end

    assign colors_out[gi*DATA_W +: DATA_W] = color_reg;
  end

  assign bg_colors  = colors_out[HALF_W-1:0];
  assign spr_colors = colors_out[2*HALF_W-1:HALF_W];

endmodule

// File: tb/tb_ppu_palette_cache.sv
// Testbench for ppu_palette_cache.
// dut0: default configuration (scoreboarded strobes, done and colours).
// dut1: RD_LAT=3, NUM_PAL=4.  dut2: MIRROR_EN=0 (snoop only).
module tb_ppu_palette_cache;

  typedef struct {
    int cyc;
    int addr;
  } rd_exp_t;

  typedef struct {
    int idx;
    int val;
  } col_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;
  int t0     = 0;
  int t1     = 0;

  rd_exp_t  rd_q[$];
  int       done_q[$];
  col_exp_t col_q[$];

  // dut0 signals
  logic         start0, busy0, done0, rd0, swe0;
  logic [15:0]  addr0, saddr0;
  logic [7:0]   vdata0, sdata0;
  logic [255:0] col0;
  logic [127:0] bg0, spr0;

  // dut1 signals
  logic         start1, busy1, done1, rd1, swe1;
  logic [15:0]  addr1, saddr1;
  logic [7:0]   vdata1, sdata1, v1_p1, v1_p2;
  logic [127:0] col1;
  logic [63:0]  bg1, spr1;

  // dut2 signals
  logic         start2, busy2, done2, rd2, swe2;
  logic [15:0]  addr2, saddr2;
  logic [7:0]   vdata2, sdata2;
  logic [255:0] col2;
  logic [127:0] bg2, spr2;

  ppu_palette_cache dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .vram_addr_out(addr0), .vram_rd(rd0), .vram_data_in(vdata0),
    .snoop_we(swe0), .snoop_addr(saddr0), .snoop_data(sdata0),
    .colors_out(col0), .bg_colors(bg0), .spr_colors(spr0)
  );

  ppu_palette_cache #(.NUM_PAL(4), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .vram_addr_out(addr1), .vram_rd(rd1), .vram_data_in(vdata1),
    .snoop_we(swe1), .snoop_addr(saddr1), .snoop_data(sdata1),
    .colors_out(col1), .bg_colors(bg1), .spr_colors(spr1)
  );

  ppu_palette_cache #(.MIRROR_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .vram_addr_out(addr2), .vram_rd(rd2), .vram_data_in(vdata2),
    .snoop_we(swe2), .snoop_addr(saddr2), .snoop_data(sdata2),
    .colors_out(col2), .bg_colors(bg2), .spr_colors(spr2)
  );

  // VRAM models: data = addr & 8'h3F after the configured latency
  always @(posedge clk) vdata0 <= addr0[7:0] & 8'h3F;
  always @(posedge clk) begin
    v1_p1  <= addr1[7:0] & 8'h3F;
    v1_p2  <= v1_p1;
    vdata1 <= v1_p2;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_entry(input int i);
    return (i % 4 == 0) ? 0 : (i & 'h3F);
  endfunction

  // Queue the expected strobes (cycles 1..n_rd), and optionally the done
  // pulse at cycle 34 with the full colour table (entry 5 overridden).
  task automatic push_load0(input int n_rd, input bit with_done, input int e5);
    rd_exp_t  r;
    col_exp_t c;
    for (int i = 0; i < n_rd; i++) begin
      r.cyc  = i + 1;
      r.addr = (i % 4 == 0) ? 'h3F00 : ('h3F00 + i);
      rd_q.push_back(r);
    end
    if (with_done) begin
      done_q.push_back(34);
      for (int i = 0; i < 32; i++) begin
        c.idx = i;
        c.val = (i == 5) ? e5 : exp_entry(i);
        col_q.push_back(c);
      end
    end
  endtask

  task automatic start_load0();
    @(negedge clk);
    start0 = 1'b1;
    t0     = cyc;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    int k;
    k = 0;
    while (!done0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done0) begin
      tests++;
      failed++;
      $display("FAIL %s: done never pulsed within 100 cycles, expected a pulse", name);
    end
    @(negedge clk);
    check({name, "_busy_after"}, int'(busy0), 0);
  endtask

  // Scoreboard monitor for dut0
  always @(negedge clk) begin
    rd_exp_t  r;
    col_exp_t c;
    int       d;
    if (rst) begin
      if (rd0) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          r = rd_q.pop_front();
          check("rd_cycle", cyc - t0, r.cyc);
          check("rd_addr", int'(addr0), r.addr);
        end
      end
      if (done0) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", cyc - t0, d);
          while (col_q.size() > 0) begin
            c = col_q.pop_front();
            check($sformatf("color[%0d]", c.idx), int'(col0[c.idx*8 +: 8]), c.val);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, n_rd1, done_rel, nd;
    rst = 1'b0;
    start0 = 0; swe0 = 0; saddr0 = 0; sdata0 = 0;
    start1 = 0; swe1 = 0; saddr1 = 0; sdata1 = 0;
    start2 = 0; swe2 = 0; saddr2 = 0; sdata2 = 0; vdata2 = 0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_rd", int'(rd0), 0);
    check("rst_addr", int'(addr0), 0);
    check("rst_colors_zero", int'(col0 == '0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy0), 0);

    // ---- default full load ----
    push_load0(32, 1'b1, 5);
    start_load0();
    check("load_busy_c1", int'(busy0), 1);
    wait_done0("load1");
    check("bg_entry5", int'(bg0[5*8 +: 8]), 'h05);
    check("spr_entry21", int'(spr0[5*8 +: 8]), 'h15);
    check("spr_entry20", int'(spr0[4*8 +: 8]), 'h00);

    // ---- RD_LAT=3, NUM_PAL=4 ----
    @(negedge clk);
    start1 = 1'b1;
    t1 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    n_rd1 = 0;
    done_rel = -1;
    for (int k = 0; k < 40; k++) begin
      rel = cyc - t1;
      if (rd1) n_rd1++;
      if (rel == 5) check("lat3_entry1_early", int'(col1[15:8]), 0);
      if (rel == 6) check("lat3_entry1_cap", int'(col1[15:8]), 1);
      if (done1 && done_rel < 0) begin
        done_rel = rel;
        check("lat3_entry15", int'(col1[127:120]), 'h0F);
      end
      @(negedge clk);
    end
    check("lat3_done_cycle", done_rel, 20);
    check("lat3_strobes", n_rd1, 16);

    // ---- idle snoop to 3F10 (mirror on dut0, off on dut2) ----
    swe0 = 1; saddr0 = 16'h3F10; sdata0 = 8'h2A;
    swe2 = 1; saddr2 = 16'h3F10; sdata2 = 8'h2A;
    @(negedge clk);
    swe0 = 0; swe2 = 0;
    for (int i = 0; i < 32; i += 4)
      check($sformatf("mirror_entry%0d", i), int'(col0[i*8 +: 8]), 'h2A);
    check("mirror_entry5_kept", int'(col0[5*8 +: 8]), 'h05);
    check("nomirror_entry16", int'(col2[16*8 +: 8]), 'h2A);
    check("nomirror_entry0", int'(col2[7:0]), 0);
    check("nomirror_entry20", int'(col2[20*8 +: 8]), 0);

    // ---- snoop through the window mirror, and a miss ----
    swe0 = 1; saddr0 = 16'h3F25; sdata0 = 8'h11;
    @(negedge clk);
    check("snoop_3F25_entry5", int'(col0[5*8 +: 8]), 'h11);
    saddr0 = 16'h3E05; sdata0 = 8'h99;
    @(negedge clk);
    swe0 = 0;
    check("snoop_miss_entry5", int'(col0[5*8 +: 8]), 'h11);

    // ---- collision at entry 5 plus ignored start while busy ----
    push_load0(32, 1'b1, 'h77);
    start_load0();
    while (cyc - t0 < 3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc - t0 < 7) @(negedge clk);
    swe0 = 1; saddr0 = 16'h3F05; sdata0 = 8'h77;
    @(negedge clk);
    swe0 = 0;
    wait_done0("collision");
    repeat (40) @(negedge clk);
    check("collision_rd_left", rd_q.size(), 0);
    check("collision_done_left", done_q.size(), 0);

    // ---- reset at cycle 10 of a load ----
    push_load0(9, 1'b0, 5);
    start_load0();
    while (cyc - t0 < 9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy0), 0);
    check("midrst_rd", int'(rd0), 0);
    check("midrst_addr", int'(addr0), 0);
    check("midrst_colors_zero", int'(col0 == '0), 1);
    check("midrst_rd_left", rd_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) nd++;
    end
    check("midrst_no_done", nd, 0);

    // ---- new load after reset ----
    push_load0(32, 1'b1, 5);
    start_load0();
    wait_done0("reload");
    repeat (5) @(negedge clk);
    check("final_rd_left", rd_q.size(), 0);
    check("final_done_left", done_q.size(), 0);
    check("final_col_left", col_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
